// File: rtl/dpe_pkg.sv
// Shared DPE stream definitions: field widths, port addresses, the beat
// record carried through the ingress multiplexer, and the round-robin helpers.
package dpe_pkg;

    localparam int DPE_DATA_W  = 64;
    localparam int DPE_KEEP_W  = DPE_DATA_W / 8;
    localparam int DPE_STAGE_W = 4;
    localparam int DPE_ADDR_W  = 4;

    localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_CPU   = 4'h8;
    localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_1 = 4'h1;
    localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_2 = 4'h2;
    localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_3 = 4'h3;
    localparam logic [DPE_ADDR_W-1:0] DPE_ADDR_ETH_4 = 4'h4;

    localparam int NUM_DPE_PORTS = 5;

    // Index 0 is CPU, indices 1..4 are ETH_1..ETH_4.
    localparam logic [NUM_DPE_PORTS-1:0][DPE_ADDR_W-1:0] DPE_MUX_PORT_ADDR =
        {DPE_ADDR_ETH_4, DPE_ADDR_ETH_3, DPE_ADDR_ETH_2, DPE_ADDR_ETH_1, DPE_ADDR_CPU};

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } dpe_mux_state_t;

    typedef logic [2:0] dpe_port_idx_t;
    localparam dpe_port_idx_t DPE_PORT_NONE = 3'd7;

    typedef struct packed {
        logic [DPE_DATA_W-1:0]  tdata;
        logic [DPE_KEEP_W-1:0]  tkeep;
        logic                   tlast;
        logic                   tuser_bypass_all;
        logic [DPE_STAGE_W-1:0] tuser_bypass_stage;
        logic [DPE_ADDR_W-1:0]  tuser_src;
        logic [DPE_ADDR_W-1:0]  tuser_dst;
    } dpe_beat_t;

    // First requesting port at or after ptr, wrapping 4 -> 0.
    function automatic dpe_port_idx_t dpe_mux_rr_pick(input logic [NUM_DPE_PORTS-1:0] req,
                                                      input dpe_port_idx_t ptr);
        int s;
        dpe_mux_rr_pick = ptr;
        for (int k = NUM_DPE_PORTS - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= NUM_DPE_PORTS) s = s - NUM_DPE_PORTS;
            if (req[s]) dpe_mux_rr_pick = dpe_port_idx_t'(s);
        end
    endfunction

    // Port index following idx, modulo the port count.
    function automatic dpe_port_idx_t dpe_mux_next_ptr(input dpe_port_idx_t idx);
        dpe_mux_next_ptr = (idx == dpe_port_idx_t'(NUM_DPE_PORTS - 1)) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dpe_if.sv
// DPE AXI-stream style bundle. master drives the beat, slave returns tready.
interface dpe_if;
    import dpe_pkg::*;

    logic [DPE_DATA_W-1:0]  tdata;
    logic [DPE_KEEP_W-1:0]  tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;
    logic                   tuser_bypass_all;
    logic [DPE_STAGE_W-1:0] tuser_bypass_stage;
    logic [DPE_ADDR_W-1:0]  tuser_src;
    logic [DPE_ADDR_W-1:0]  tuser_dst;

    modport master (
        output tdata, tkeep, tlast, tvalid, tuser_bypass_all, tuser_bypass_stage,
               tuser_src, tuser_dst,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid, tuser_bypass_all, tuser_bypass_stage,
               tuser_src, tuser_dst,
        output tready
    );

endinterface

// File: rtl/dpe_skid_buffer.sv
// Two-entry registered slice on dpe_if. Upstream tready is taken from the
// skid occupancy flop only, so downstream tready never reaches upstream
// combinationally; at most two words are absorbed while the output stalls.
module dpe_skid_buffer
    import dpe_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    dpe_if.slave  s_in,
    dpe_if.master m_out
);

    dpe_beat_t in_beat;
    dpe_beat_t out_q, out_d;
    dpe_beat_t skid_q, skid_d;
    logic      out_vld_q, out_vld_d;
    logic      skid_vld_q, skid_vld_d;
    logic      push, pop;

    assign in_beat = {s_in.tdata, s_in.tkeep, s_in.tlast, s_in.tuser_bypass_all,
                      s_in.tuser_bypass_stage, s_in.tuser_src, s_in.tuser_dst};

    assign s_in.tready = !skid_vld_q;
    assign push        = s_in.tvalid && !skid_vld_q;
    assign pop         = out_vld_q && m_out.tready;

    // Next occupancy: refill the output word from the skid first, then from the input.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || pop) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_d     = in_beat;
                skid_vld_d = push;
            end else begin
                out_d      = in_beat;
                out_vld_d  = push;
            end
        end else if (push) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
    end

    // Output and skid registers; reset empties both and zeroes the egress fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign m_out.tvalid             = out_vld_q;
    assign m_out.tdata              = out_q.tdata;
    assign m_out.tkeep              = out_q.tkeep;
    assign m_out.tlast              = out_q.tlast;
    assign m_out.tuser_bypass_all   = out_q.tuser_bypass_all;
    assign m_out.tuser_bypass_stage = out_q.tuser_bypass_stage;
    assign m_out.tuser_src          = out_q.tuser_src;
    assign m_out.tuser_dst          = out_q.tuser_dst;

endmodule

// File: rtl/dpe_multiplexer.sv
// Ingress merger: five packet streams (CPU, ETH_1..ETH_4) into one DPE stream.
// Packet-atomic round-robin, one idle cycle of arbitration per packet, source
// address stamping and a registered skid output stage.
// Optional macro DPE_MUX_CPU_PRIO_EN: CPU wins every arbitration it takes part
// in, and the round-robin pointer moves only on ETH grants.
module dpe_multiplexer
    import dpe_pkg::*;
#(
    parameter int NUM_IN    = 5,
    parameter bit SRC_STAMP = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    dpe_if.slave  from_cpu,
    dpe_if.slave  from_eth_1,
    dpe_if.slave  from_eth_2,
    dpe_if.slave  from_eth_3,
    dpe_if.slave  from_eth_4,
    dpe_if.master to_dpe
);

    dpe_if mux_if ();

    dpe_mux_state_t      state_q, state_d;
    dpe_port_idx_t       grant_q, grant_d;
    dpe_port_idx_t       rr_ptr_q, rr_ptr_d;
    dpe_port_idx_t       pick;
    logic                advance;

    logic [NUM_IN-1:0]   in_valid;
    logic [NUM_IN-1:0]   in_ready;
    dpe_beat_t           in_beat [NUM_IN];
    dpe_beat_t           sel_beat;
    logic                sel_valid;
    logic                xfer_hs;

    assign in_valid = {from_eth_4.tvalid, from_eth_3.tvalid, from_eth_2.tvalid,
                       from_eth_1.tvalid, from_cpu.tvalid};

    assign in_beat[0] = {from_cpu.tdata, from_cpu.tkeep, from_cpu.tlast,
                         from_cpu.tuser_bypass_all, from_cpu.tuser_bypass_stage,
                         from_cpu.tuser_src, from_cpu.tuser_dst};
    assign in_beat[1] = {from_eth_1.tdata, from_eth_1.tkeep, from_eth_1.tlast,
                         from_eth_1.tuser_bypass_all, from_eth_1.tuser_bypass_stage,
                         from_eth_1.tuser_src, from_eth_1.tuser_dst};
    assign in_beat[2] = {from_eth_2.tdata, from_eth_2.tkeep, from_eth_2.tlast,
                         from_eth_2.tuser_bypass_all, from_eth_2.tuser_bypass_stage,
                         from_eth_2.tuser_src, from_eth_2.tuser_dst};
    assign in_beat[3] = {from_eth_3.tdata, from_eth_3.tkeep, from_eth_3.tlast,
                         from_eth_3.tuser_bypass_all, from_eth_3.tuser_bypass_stage,
                         from_eth_3.tuser_src, from_eth_3.tuser_dst};
    assign in_beat[4] = {from_eth_4.tdata, from_eth_4.tkeep, from_eth_4.tlast,
                         from_eth_4.tuser_bypass_all, from_eth_4.tuser_bypass_stage,
                         from_eth_4.tuser_src, from_eth_4.tuser_dst};

    // Select the granted port's beat and give only that port tready (skid space permitting).
    always_comb begin
        sel_beat  = '0;
        sel_valid = 1'b0;
        in_ready  = '0;
        if (state_q == XFER) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (grant_q == dpe_port_idx_t'(i)) begin
                    sel_beat    = in_beat[i];
                    sel_valid   = in_valid[i];
                    in_ready[i] = mux_if.tready;
                    if (SRC_STAMP) sel_beat.tuser_src = DPE_MUX_PORT_ADDR[i];
                end
            end
        end
    end

    assign xfer_hs = sel_valid && mux_if.tready;

    assign from_cpu.tready   = in_ready[0];
    assign from_eth_1.tready = in_ready[1];
    assign from_eth_2.tready = in_ready[2];
    assign from_eth_3.tready = in_ready[3];
    assign from_eth_4.tready = in_ready[4];

    assign mux_if.tvalid             = sel_valid;
    assign mux_if.tdata              = sel_beat.tdata;
    assign mux_if.tkeep              = sel_beat.tkeep;
    assign mux_if.tlast              = sel_beat.tlast;
    assign mux_if.tuser_bypass_all   = sel_beat.tuser_bypass_all;
    assign mux_if.tuser_bypass_stage = sel_beat.tuser_bypass_stage;
    assign mux_if.tuser_src          = sel_beat.tuser_src;
    assign mux_if.tuser_dst          = sel_beat.tuser_dst;

`ifdef DPE_MUX_CPU_PRIO_EN
    assign pick    = in_valid[0] ? '0 : dpe_mux_rr_pick(in_valid, rr_ptr_q);
    assign advance = (grant_q != '0);
`else
    assign pick    = dpe_mux_rr_pick(in_valid, rr_ptr_q);
    assign advance = 1'b1;
`endif

    // Arbitration FSM: grant in IDLE, hold the grant until the packet's tlast handshake.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (xfer_hs && sel_beat.tlast) begin
                    state_d = IDLE;
                    grant_d = DPE_PORT_NONE;
                    if (advance) rr_ptr_d = dpe_mux_next_ptr(grant_q);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = DPE_PORT_NONE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= DPE_PORT_NONE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    dpe_skid_buffer u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .s_in  (mux_if.slave),
        .m_out (to_dpe)
    );

endmodule

// File: tb/tb_dpe_multiplexer.sv
// Scoreboard bench for dpe_multiplexer: drivers push expected beats per source
// as they issue them; a monitor pops and compares every egress word, checks
// that packets never interleave and, where the arbitration outcome is fixed,
// that packets leave in the expected port order.
module tb_dpe_multiplexer;
    import dpe_pkg::*;

    localparam int TIMEOUT = 300;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dpe_if in_if [5] ();
    dpe_if out_if ();

    dpe_beat_t  drv_beat [5];
    logic [4:0] drv_valid;
    logic [4:0] drv_ready;
    logic       out_rdy;
    dpe_beat_t  mon_beat;

    for (genvar g = 0; g < 5; g++) begin : g_bind
        assign in_if[g].tdata              = drv_beat[g].tdata;
        assign in_if[g].tkeep              = drv_beat[g].tkeep;
        assign in_if[g].tlast              = drv_beat[g].tlast;
        assign in_if[g].tuser_bypass_all   = drv_beat[g].tuser_bypass_all;
        assign in_if[g].tuser_bypass_stage = drv_beat[g].tuser_bypass_stage;
        assign in_if[g].tuser_src          = drv_beat[g].tuser_src;
        assign in_if[g].tuser_dst          = drv_beat[g].tuser_dst;
        assign in_if[g].tvalid             = drv_valid[g];
        assign drv_ready[g]                = in_if[g].tready;
    end

    assign out_if.tready = out_rdy;
    assign mon_beat = {out_if.tdata, out_if.tkeep, out_if.tlast, out_if.tuser_bypass_all,
                       out_if.tuser_bypass_stage, out_if.tuser_src, out_if.tuser_dst};

    dpe_multiplexer #(.NUM_IN(5), .SRC_STAMP(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .from_cpu   (in_if[0]),
        .from_eth_1 (in_if[1]),
        .from_eth_2 (in_if[2]),
        .from_eth_3 (in_if[3]),
        .from_eth_4 (in_if[4]),
        .to_dpe     (out_if)
    );

    int        total = 0;
    int        bad   = 0;
    dpe_beat_t exp_q [5][$];
    int        exp_order [$];
    int        lat_q [$];
    bit        chk_lat = 1'b0;
    bit        occ_chk = 1'b0;
    int        in_cnt  = 0;
    int        out_cnt = 0;
    int        cyc     = 0;
    int        rdy_mode = 0;
    int        pat_i   = 0;
    bit        in_pkt  = 1'b0;
    int        cur_port = 0;
    int        mon_p;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Port addresses the stream must carry in tuser_src.
    function automatic logic [3:0] addr_of(input int p);
        case (p)
            0: addr_of = 4'h8;
            1: addr_of = 4'h1;
            2: addr_of = 4'h2;
            3: addr_of = 4'h3;
            default: addr_of = 4'h4;
        endcase
    endfunction

    function automatic int port_of(input logic [3:0] a);
        case (a)
            4'h8: port_of = 0;
            4'h1: port_of = 1;
            4'h2: port_of = 2;
            4'h3: port_of = 3;
            4'h4: port_of = 4;
            default: port_of = -1;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Egress ready generator.
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_rdy = 1'b1;
            1: begin
                out_rdy = (pat_i < 7) || (pat_i >= 8 && pat_i < 12);
                pat_i   = (pat_i + 1) % 15;
            end
            2: out_rdy = ($urandom_range(0, 3) != 0);
            default: out_rdy = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_pkt = 1'b0;
        end else if (out_if.tvalid && out_rdy) begin
            out_cnt++;
            mon_p = port_of(mon_beat.tuser_src);
            if (mon_p < 0) begin
                total++; bad++;
                $display("FAIL src_addr: got %0h expected a port address", mon_beat.tuser_src);
            end else begin
                if (in_pkt) chk("no_interleave", mon_p, cur_port);
                if (exp_q[mon_p].size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word: got %0h from port %0d expected none", mon_beat, mon_p);
                end else begin
                    chk("beat", mon_beat, exp_q[mon_p].pop_front());
                end
                if (chk_lat && lat_q.size() > 0) chk("latency", cyc, lat_q.pop_front() + 1);
                if (mon_beat.tlast) begin
                    in_pkt = 1'b0;
                    if (exp_order.size() > 0) chk("pkt_order", mon_p, exp_order.pop_front());
                end else begin
                    in_pkt   = 1'b1;
                    cur_port = mon_p;
                end
            end
        end
    end

    // Per-cycle structural checks: one tready at most, skid never over two words.
    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n && occ_chk) begin
            chk("single_tready", ($countones(drv_ready) <= 1), 1);
            chk("skid_occupancy", ((in_cnt - out_cnt) <= 2), 1);
        end
    end

    task automatic send_pkt(input int p, input int len, input logic [7:0] base,
                            input int gap_at, input int gap_len);
        dpe_beat_t b;
        dpe_beat_t e;
        bit        hs;
        int        n;
        for (int w = 0; w < len; w++) begin
            if (w == gap_at && gap_len > 0) begin
                drv_valid[p] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            b.tdata              = {32'($urandom()), 24'($urandom()), base + 8'(w)};
            b.tkeep              = 8'($urandom());
            b.tlast              = (w == len - 1);
            b.tuser_bypass_all   = 1'($urandom());
            b.tuser_bypass_stage = 4'($urandom());
            b.tuser_src          = 4'($urandom());
            b.tuser_dst          = 4'($urandom());
            drv_beat[p]  = b;
            drv_valid[p] = 1'b1;
            e = b;
            e.tuser_src = addr_of(p);
            exp_q[p].push_back(e);
            hs = 1'b0;
            n  = 0;
            while (!hs) begin
                @(negedge clk);
                if (!rst_n) begin
                    drv_valid[p] = 1'b0;
                    return;
                end
                hs = drv_ready[p];
                if (hs) begin
                    in_cnt++;
                    if (chk_lat) lat_q.push_back(cyc);
                end
                @(posedge clk);
                #1;
                n++;
                if (!hs && n > TIMEOUT) begin
                    total++; bad++;
                    $display("FAIL ingress_timeout: port %0d word %0d got no tready expected within %0d cycles", p, w, TIMEOUT);
                    drv_valid[p] = 1'b0;
                    return;
                end
            end
        end
        drv_valid[p] = 1'b0;
    endtask

    task automatic port_rand(input int p);
        int npk;
        npk = $urandom_range(0, 3);
        for (int k = 0; k < npk; k++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            send_pkt(p, $urandom_range(1, 8), 8'($urandom()), $urandom_range(0, 7), $urandom_range(0, 2));
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < 2000) begin
            pending = (exp_order.size() != 0);
            for (int i = 0; i < 5; i++) if (exp_q[i].size() != 0) pending = 1'b1;
            if (pending) begin
                @(posedge clk);
                n++;
            end
        end
        total++;
        if (pending) begin
            bad++;
            $display("FAIL drain_%s: got words still pending expected all delivered", name);
            for (int i = 0; i < 5; i++) exp_q[i].delete();
            exp_order.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_cnt  = 0;
        out_cnt = 0;
        rst_n   = 1'b1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        out_rdy   = 1'b1;
        drv_valid = 5'h1F;
        for (int i = 0; i < 5; i++) drv_beat[i] = dpe_beat_t'({$urandom(), $urandom(), $urandom()});

        // Reset with every ingress asserting tvalid.
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_tvalid", out_if.tvalid, 0);
            chk("rst_in_tready", drv_ready, 0);
            chk("rst_out_fields", mon_beat, 0);
        end
        @(posedge clk);
        #1;
        drv_valid = '0;
        rst_n = 1'b1;

        // CPU 6-word packet with ETH_2 also pending: CPU first, one-cycle latency.
        chk_lat = 1'b1;
        exp_order = '{0, 2};
        fork
            send_pkt(0, 6, 8'h01, -1, 0);
            send_pkt(2, 3, 8'h20, -1, 0);
        join
        wait_drain("cpu_first");
        chk_lat = 1'b0;
        lat_q.delete();

        // All five ports at once from rr_ptr=0.
        apply_reset();
        occ_chk = 1'b1;
        exp_order = '{0, 1, 2, 3, 4};
        fork
            send_pkt(0, 6, 8'h01, -1, 0);
            send_pkt(1, 4, 8'h11, -1, 0);
            send_pkt(2, 5, 8'h21, -1, 0);
            send_pkt(3, 4, 8'h31, -1, 0);
            send_pkt(4, 4, 8'h41, -1, 0);
        join
        wait_drain("all_five");

        // ETH_2 packet 15..19 under the egress stall pattern.
        rdy_mode = 1;
        pat_i = 0;
        exp_order = '{2};
        send_pkt(2, 5, 8'h15, -1, 0);
        wait_drain("stall_pattern");
        rdy_mode = 0;

        // ETH_3 pauses mid-packet while ETH_1 waits (rr_ptr=3 here).
        exp_order = '{3, 1};
        fork
            send_pkt(3, 6, 8'h30, 3, 3);
            send_pkt(1, 4, 8'h10, -1, 0);
        join
        wait_drain("mid_pkt_gap");

        // Single-word CPU packet, then CPU and ETH_1 contending.
        apply_reset();
        exp_order = '{0};
        send_pkt(0, 1, 8'hC0, -1, 0);
        wait_drain("single_word");
`ifdef DPE_MUX_CPU_PRIO_EN
        exp_order = '{0, 1};
`else
        exp_order = '{1, 0};
`endif
        fork
            send_pkt(0, 2, 8'hC1, -1, 0);
            send_pkt(1, 2, 8'h1A, -1, 0);
        join
        wait_drain("cpu_vs_eth1");

        // Randomised traffic with random egress back-pressure.
        rdy_mode = 2;
        for (int r = 0; r < 6; r++) begin
            fork
                port_rand(0);
                port_rand(1);
                port_rand(2);
                port_rand(3);
                port_rand(4);
            join
            wait_drain("random");
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Reset in the middle of a buffered packet.
        occ_chk = 1'b0;
        rdy_mode = 3;
        @(posedge clk);
        #1;
        in_cnt = 0;
        out_cnt = 0;
        fork
            send_pkt(4, 6, 8'h40, -1, 0);
            begin
                n = 0;
                while (in_cnt < 2 && n < 50) begin
                    @(posedge clk);
                    n++;
                end
                @(posedge clk);
                #3;
                chk("midrst_pre_tvalid", out_if.tvalid, 1);
                chk("midrst_pre_stalled", drv_ready, 0);
                rst_n = 1'b0;
                #1;
                chk("midrst_tvalid_falls", out_if.tvalid, 0);
                chk("midrst_fields_zero", mon_beat, 0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        for (int i = 0; i < 5; i++) exp_q[i].delete();
        exp_order.delete();
        rdy_mode = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_empty", out_if.tvalid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
